// File: rtl/ysyx_22041207_me_access.sv
// Memory-access stage: each load/store becomes one single-beat AXI4-Lite transaction on a 64-bit bus.
// Define ME_ACCESS_FAULT_EN to add the memFault output and return zero data on faulting loads.
module ysyx_22041207_me_access #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [63:0]         aluRes,
    input  logic                memoryReadWen,
    input  logic [3:0]          readNum,
    input  logic                sext,
    input  logic [63:0]         rs2,
    input  logic [7:0]          memoryWriteMask,
    output logic                me_wait_for_axi,
    output logic [DATA_W-1:0]   memRdata,
    output logic                memDone,
`ifdef ME_ACCESS_FAULT_EN
    output logic                memFault,
`endif
    output logic                arvalid,
    input  logic                arready,
    output logic [ADDR_W-1:0]   araddr,
    input  logic                rvalid,
    output logic                rready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    output logic                awvalid,
    input  logic                awready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                wvalid,
    input  logic                wready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    input  logic                bvalid,
    output logic                bready,
    input  logic [1:0]          bresp
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW_W,
        S_B,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          readNum_q, readNum_d;
    logic                sext_q, sext_d;
    logic [2:0]          off_q, off_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic                awDone_q, awDone_d;
    logic                wDone_q, wDone_d;
    logic [DATA_W-1:0]   memRdata_q, memRdata_d;
`ifdef ME_ACCESS_FAULT_EN
    logic                fault_q, fault_d;
`else
    logic                unusedResp;
    assign unusedResp = ^{rresp, bresp};
`endif

    logic                reqRd, reqWr;
    logic                awHs, wHs;
    logic [DATA_W-1:0]   shifted, loadVal;

    // A load wins over a store when both are requested in the same instruction.
    assign reqRd = memoryReadWen;
    assign reqWr = (|memoryWriteMask) & ~memoryReadWen;

    assign arvalid = (state_q == S_AR);
    assign rready  = (state_q == S_R);
    assign awvalid = (state_q == S_AW_W) & ~awDone_q;
    assign wvalid  = (state_q == S_AW_W) & ~wDone_q;
    assign bready  = (state_q == S_B);
    assign araddr  = addr_q;
    assign awaddr  = addr_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign awHs    = awvalid & awready;
    assign wHs     = wvalid & wready;

    assign memDone  = (state_q == S_DONE);
    assign memRdata = memRdata_q;
`ifdef ME_ACCESS_FAULT_EN
    assign memFault = (state_q == S_DONE) & fault_q;
`endif

    // The stall drops in DONE so EX/ME can present the next instruction while we finish.
    assign me_wait_for_axi = ((state_q == S_IDLE) & (reqRd | reqWr)) |
                             (state_q == S_AR) | (state_q == S_R) |
                             (state_q == S_AW_W) | (state_q == S_B);

    always_comb begin
        shifted = rdata >> {off_q, 3'b000};
        loadVal = shifted;
        case (readNum_q)
            4'd1:    loadVal = {{56{sext_q & shifted[7]}},  shifted[7:0]};
            4'd2:    loadVal = {{48{sext_q & shifted[15]}}, shifted[15:0]};
            4'd4:    loadVal = {{32{sext_q & shifted[31]}}, shifted[31:0]};
            default: loadVal = shifted;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        readNum_d  = readNum_q;
        sext_d     = sext_q;
        off_d      = off_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        awDone_d   = awDone_q;
        wDone_d    = wDone_q;
        memRdata_d = memRdata_q;
`ifdef ME_ACCESS_FAULT_EN
        fault_d    = fault_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (reqRd) begin
                    state_d   = S_AR;
                    addr_d    = {aluRes[ADDR_W-1:3], 3'b000};
                    readNum_d = readNum;
                    sext_d    = sext;
                    off_d     = aluRes[2:0];
                end else if (reqWr) begin
                    state_d  = S_AW_W;
                    addr_d   = {aluRes[ADDR_W-1:3], 3'b000};
                    off_d    = aluRes[2:0];
                    wdata_d  = rs2 << {aluRes[2:0], 3'b000};
                    wstrb_d  = memoryWriteMask << aluRes[2:0];
                    awDone_d = 1'b0;
                    wDone_d  = 1'b0;
                end
            end
            S_AR: begin
                if (arready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                if (rvalid) begin
                    state_d    = S_DONE;
                    memRdata_d = loadVal;
`ifdef ME_ACCESS_FAULT_EN
                    fault_d    = (rresp != 2'b00);
                    if (rresp != 2'b00) begin
                        memRdata_d = '0;
                    end
`endif
                end
            end
            S_AW_W: begin
                // Address and data channels complete independently, in either order.
                awDone_d = awDone_q | awHs;
                wDone_d  = wDone_q | wHs;
                if ((awDone_q | awHs) & (wDone_q | wHs)) begin
                    state_d = S_B;
                end
            end
            S_B: begin
                if (bvalid) begin
                    state_d = S_DONE;
`ifdef ME_ACCESS_FAULT_EN
                    fault_d = (bresp != 2'b00);
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            readNum_q  <= '0;
            sext_q     <= 1'b0;
            off_q      <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awDone_q   <= 1'b0;
            wDone_q    <= 1'b0;
            memRdata_q <= '0;
`ifdef ME_ACCESS_FAULT_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            readNum_q  <= readNum_d;
            sext_q     <= sext_d;
            off_q      <= off_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awDone_q   <= awDone_d;
            wDone_q    <= wDone_d;
            memRdata_q <= memRdata_d;
`ifdef ME_ACCESS_FAULT_EN
            fault_q    <= fault_d;
`endif
        end
    end

endmodule

// File: tb/tb_ysyx_22041207_me_access.sv
// Bench for ysyx_22041207_me_access: byte-level memory model, scoreboard of expected completions,
// and a configurable-latency AXI4-Lite slave.
module tb_ysyx_22041207_me_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] aluRes;
    logic        memoryReadWen;
    logic [3:0]  readNum;
    logic        sext;
    logic [63:0] rs2;
    logic [7:0]  memoryWriteMask;
    logic        me_wait_for_axi;
    logic [63:0] memRdata;
    logic        memDone;
`ifdef ME_ACCESS_FAULT_EN
    logic        memFault;
`endif
    logic        arvalid, arready, rvalid, rready;
    logic [63:0] araddr, rdata;
    logic [1:0]  rresp, bresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [63:0] awaddr, wdata;
    logic [7:0]  wstrb;

    always #5 clk = ~clk;

    ysyx_22041207_me_access dut (
        .clk(clk), .rst(rst), .aluRes(aluRes), .memoryReadWen(memoryReadWen),
        .readNum(readNum), .sext(sext), .rs2(rs2), .memoryWriteMask(memoryWriteMask),
        .me_wait_for_axi(me_wait_for_axi), .memRdata(memRdata), .memDone(memDone),
`ifdef ME_ACCESS_FAULT_EN
        .memFault(memFault),
`endif
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    typedef struct { logic isLoad; logic [63:0] data; logic fault; } exp_t;
    typedef struct { logic [63:0] addr; logic [63:0] data; logic [7:0] strb; } wr_t;

    exp_t        expQ[$];
    logic [63:0] expRdQ[$];
    wr_t         expWrQ[$];
    logic [7:0]  refMem [logic [63:0]];
    logic [63:0] slaveMem [logic [63:0]];

    int nCompared = 0;
    int nMismatched = 0;
    int doneCount = 0;
    logic [63:0] lastDoneData;
    logic [63:0] lastAwaddr, lastWdata;
    logic [7:0]  lastWstrb;
    logic stallViolation = 1'b0;

    // Slave timing knobs, set by the stimulus before each access.
    int arDelay = 0, awDelay = 0, wDelay = 0, rDelay = 0, bDelay = 0;
    int arCnt = 0, awCnt = 0, wCnt = 0;
    logic [1:0] curResp = 2'b00;

    assign arready = (arCnt >= arDelay);
    assign awready = (awCnt >= awDelay);
    assign wready  = (wCnt >= wDelay);

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] initByte(input logic [63:0] a);
        logic [63:0] t;
        t = (a * 64'd37) ^ (a >> 5);
        return t[7:0];
    endfunction

    function automatic logic [7:0] refByte(input logic [63:0] a);
        return refMem.exists(a) ? refMem[a] : initByte(a);
    endfunction

    function automatic logic [63:0] slaveWord(input logic [63:0] base);
        logic [63:0] w;
        if (slaveMem.exists(base)) return slaveMem[base];
        for (int k = 0; k < 8; k++) w[8*k +: 8] = initByte(base + 64'(k));
        return w;
    endfunction

    // Reference load: gather the requested bytes that fall inside the aligned word, then extend.
    function automatic logic [63:0] refLoad(input logic [63:0] addr, input logic [3:0] rn, input logic sx);
        int n;
        int off;
        logic [63:0] v;
        n = (rn == 4'd1 || rn == 4'd2 || rn == 4'd4 || rn == 4'd8) ? int'(rn) : 8;
        off = int'(addr[2:0]);
        v = '0;
        for (int i = 0; i < n; i++)
            if (off + i < 8) v[8*i +: 8] = refByte(addr + 64'(i));
        if (sx && n < 8 && v[8*n-1])
            for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Slave: samples handshakes at negedge, updates its outputs just after the following posedge.
    logic sAr, sR, sAw, sW, sB, sArv, sAwv, sWv;
    logic [63:0] sAraddr, sAwaddr, sWdata, rAddr, curAw, curW;
    logic [7:0]  sWstrb, curStrb;
    logic pendR = 1'b0, pendB = 1'b0, awGot = 1'b0, wGot = 1'b0;
    logic awReassert = 1'b0, bEarly = 1'b0, sawWrite = 1'b0;
    int rWait = 0, bWait = 0;

    initial begin
        rvalid = 1'b0; rdata = '0; rresp = '0; bvalid = 1'b0; bresp = '0;
        forever begin
            @(negedge clk);
            sAr = arvalid && arready;  sR = rvalid && rready;
            sAw = awvalid && awready;  sW = wvalid && wready;  sB = bvalid && bready;
            sArv = arvalid; sAwv = awvalid; sWv = wvalid;
            sAraddr = araddr; sAwaddr = awaddr; sWdata = wdata; sWstrb = wstrb;
            if (awvalid && awGot) awReassert = 1'b1;
            if (bready && !wGot) bEarly = 1'b1;
            if (awvalid || wvalid) sawWrite = 1'b1;
            @(posedge clk);
            #1;
            if (rst) begin
                rvalid = 1'b0; bvalid = 1'b0; pendR = 1'b0; pendB = 1'b0;
                awGot = 1'b0; wGot = 1'b0; awReassert = 1'b0; bEarly = 1'b0; sawWrite = 1'b0;
                arCnt = 0; awCnt = 0; wCnt = 0;
                continue;
            end
            arCnt = sAr ? 0 : (sArv ? arCnt + 1 : 0);
            awCnt = sAw ? 0 : (sAwv ? awCnt + 1 : 0);
            wCnt  = sW  ? 0 : (sWv  ? wCnt + 1  : 0);
            if (sR) begin
                rvalid = 1'b0;
                checkOutput("no_write_during_load", {63'd0, sawWrite}, 64'd0);
                sawWrite = 1'b0;
            end
            if (sAr) begin
                if (expRdQ.size() == 0) checkOutput("unexpected_ar", 64'd1, 64'd0);
                else checkOutput("araddr", sAraddr, expRdQ.pop_front());
                rAddr = sAraddr; rWait = rDelay; pendR = 1'b1;
            end
            if (pendR) begin
                if (rWait == 0) begin
                    rvalid = 1'b1; rdata = slaveWord(rAddr); rresp = curResp; pendR = 1'b0;
                end else rWait--;
            end
            if (sAw) begin awGot = 1'b1; curAw = sAwaddr; end
            if (sW) begin wGot = 1'b1; curW = sWdata; curStrb = sWstrb; end
            if ((sAw || sW) && awGot && wGot) begin
                logic [63:0] w;
                lastAwaddr = curAw; lastWdata = curW; lastWstrb = curStrb;
                if (expWrQ.size() == 0) checkOutput("unexpected_write", 64'd1, 64'd0);
                else begin
                    wr_t e;
                    e = expWrQ.pop_front();
                    checkOutput("awaddr", curAw, e.addr);
                    checkOutput("wdata", curW, e.data);
                    checkOutput("wstrb", {56'd0, curStrb}, {56'd0, e.strb});
                end
                w = slaveWord(curAw);
                for (int k = 0; k < 8; k++) if (curStrb[k]) w[8*k +: 8] = curW[8*k +: 8];
                slaveMem[curAw] = w;
                pendB = 1'b1; bWait = bDelay;
            end
            if (sB) begin
                bvalid = 1'b0;
                checkOutput("aw_single_handshake", {63'd0, awReassert}, 64'd0);
                checkOutput("b_after_w", {63'd0, bEarly}, 64'd0);
                awGot = 1'b0; wGot = 1'b0; awReassert = 1'b0; bEarly = 1'b0; sawWrite = 1'b0;
            end
            if (pendB) begin
                if (bWait == 0) begin bvalid = 1'b1; bresp = curResp; pendB = 1'b0; end
                else bWait--;
            end
        end
    end

    // Scoreboard monitor: every completion pulse retires the oldest expected access.
    initial begin
        forever begin
            @(negedge clk);
            if ((arvalid || rready || awvalid || wvalid || bready) && !me_wait_for_axi)
                stallViolation = 1'b1;
`ifdef ME_ACCESS_FAULT_EN
            if (memFault && !memDone) checkOutput("fault_without_done", 64'd1, 64'd0);
`endif
            if (memDone === 1'b1) begin
                checkOutput("stall_low_in_done", {63'd0, me_wait_for_axi}, 64'd0);
                if (expQ.size() == 0) checkOutput("unexpected_done", 64'd1, 64'd0);
                else begin
                    exp_t e;
                    e = expQ.pop_front();
                    if (e.isLoad) checkOutput("load_data", memRdata, e.data);
`ifdef ME_ACCESS_FAULT_EN
                    checkOutput("mem_fault", {63'd0, memFault}, {63'd0, e.fault});
`endif
                end
                lastDoneData = memRdata;
                doneCount++;
            end
        end
    end

    task automatic resetDut();
        @(negedge clk);
        rst = 1'b1; memoryReadWen = 1'b0; memoryWriteMask = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expQ.delete(); expRdQ.delete(); expWrQ.delete();
    endtask

    task automatic applyStimulus(input logic rd, input logic [63:0] addr, input logic [3:0] rn,
                                 input logic sx, input logic [63:0] data, input logic [7:0] mask,
                                 input logic [1:0] resp, output int lat);
        exp_t e;
        wr_t  w;
        int   off;
        int   target;
        curResp = resp;
        off = int'(addr[2:0]);
        @(negedge clk);
        aluRes = addr; memoryReadWen = rd; readNum = rn; sext = sx; rs2 = data; memoryWriteMask = mask;
        e.fault = (resp != 2'b00);
        if (rd) begin
            e.isLoad = 1'b1;
            e.data = refLoad(addr, rn, sx);
`ifdef ME_ACCESS_FAULT_EN
            if (e.fault) e.data = '0;
`endif
            expRdQ.push_back({addr[63:3], 3'b000});
        end else begin
            e.isLoad = 1'b0;
            e.data = '0;
            w.addr = {addr[63:3], 3'b000}; w.data = '0; w.strb = '0;
            for (int i = 0; i + off < 8; i++) begin
                w.data[8*(i+off) +: 8] = data[8*i +: 8];
                w.strb[i+off] = mask[i];
                if (mask[i]) refMem[addr + 64'(i)] = data[8*i +: 8];
            end
            expWrQ.push_back(w);
        end
        expQ.push_back(e);
        #1;
        checkOutput("stall_on_request", {63'd0, me_wait_for_axi}, 64'd1);
        target = doneCount + 1;
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                memoryReadWen = 1'b0; memoryWriteMask = '0;
                aluRes = {$urandom, $urandom}; rs2 = {$urandom, $urandom};
                readNum = 4'($urandom); sext = 1'($urandom);
            end
            #2;
            if (doneCount >= target) break;
            if (lat >= 80) begin
                checkOutput("completion_timeout", 64'(lat), 64'd0);
                resetDut();
                break;
            end
        end
    endtask

    initial begin
        int lat;
        logic [3:0] rnTab[6];
        logic [7:0] maskTab[4];
        rnTab = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd0};
        maskTab = '{8'h01, 8'h03, 8'h0F, 8'hFF};
        rst = 1'b1; aluRes = '0; memoryReadWen = 1'b0; readNum = 4'd8; sext = 1'b0;
        rs2 = '0; memoryWriteMask = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_arvalid", {63'd0, arvalid}, 64'd0);
        checkOutput("reset_awvalid", {63'd0, awvalid}, 64'd0);
        checkOutput("reset_wvalid", {63'd0, wvalid}, 64'd0);
        checkOutput("reset_rready", {63'd0, rready}, 64'd0);
        checkOutput("reset_bready", {63'd0, bready}, 64'd0);
        checkOutput("reset_memDone", {63'd0, memDone}, 64'd0);
        checkOutput("reset_memRdata", memRdata, 64'd0);
        checkOutput("reset_araddr", araddr, 64'd0);
        checkOutput("reset_awaddr", awaddr, 64'd0);
        checkOutput("reset_wdata", wdata, 64'd0);
        checkOutput("reset_wstrb", {56'd0, wstrb}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("idle_no_stall", {63'd0, me_wait_for_axi}, 64'd0);

        // Load with sign extension, ready-always slave.
        applyStimulus(1'b0, 64'h80000004, 4'd8, 1'b0, 64'h87654321, 8'h0F, 2'b00, lat);
        applyStimulus(1'b1, 64'h80000004, 4'd4, 1'b1, 64'd0, 8'h00, 2'b00, lat);
        checkOutput("t1_data", lastDoneData, 64'hFFFFFFFF87654321);
        checkOutput("t1_latency", 64'(lat), 64'd3);

        // Single byte from the top lane, zero-extended.
        applyStimulus(1'b0, 64'h80000017, 4'd8, 1'b0, 64'hAB, 8'h01, 2'b00, lat);
        applyStimulus(1'b1, 64'h80000017, 4'd1, 1'b0, 64'd0, 8'h00, 2'b00, lat);
        checkOutput("t2_data", lastDoneData, 64'h00000000000000AB);

        // Halfword store at offset 2.
        applyStimulus(1'b0, 64'h80000002, 4'd8, 1'b0, 64'h1234, 8'h03, 2'b00, lat);
        checkOutput("t3_awaddr", lastAwaddr, 64'h80000000);
        checkOutput("t3_wstrb", {56'd0, lastWstrb}, 64'h0C);
        checkOutput("t3_wdata", lastWdata, 64'h0000000012340000);
        checkOutput("t3_latency", 64'(lat), 64'd3);

        // Address channel accepted early, data channel late.
        awDelay = 1; wDelay = 4;
        applyStimulus(1'b0, 64'h80000010, 4'd8, 1'b0, 64'h0123456789ABCDEF, 8'hFF, 2'b00, lat);
        checkOutput("t4_latency", 64'(lat), 64'd7);
        awDelay = 0; wDelay = 0;

        // Load and store requested together: only the load is performed.
        applyStimulus(1'b1, 64'h80000010, 4'd8, 1'b0, 64'hFFFF, 8'hFF, 2'b00, lat);

        // Reset while waiting for read data.
        rDelay = 4;
        @(negedge clk);
        aluRes = 64'h80000008; memoryReadWen = 1'b1; readNum = 4'd8; sext = 1'b0;
        expRdQ.push_back(64'h80000008);
        @(negedge clk);
        memoryReadWen = 1'b0;
        for (int i = 0; i < 10 && !rready; i++) @(negedge clk);
        checkOutput("t5_reached_r", {63'd0, rready}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("t5_rready_after_rst", {63'd0, rready}, 64'd0);
        checkOutput("t5_no_done_after_rst", {63'd0, memDone}, 64'd0);
        checkOutput("t5_arvalid_after_rst", {63'd0, arvalid}, 64'd0);
        rst = 1'b0;
        expRdQ.delete();
        rDelay = 0;
        repeat (4) @(negedge clk);

`ifdef ME_ACCESS_FAULT_EN
        applyStimulus(1'b1, 64'h80000004, 4'd4, 1'b1, 64'd0, 8'h00, 2'b10, lat);
        checkOutput("t6_fault_data", lastDoneData, 64'd0);
`endif

        // Randomized traffic with random slave latencies and responses.
        for (int n = 0; n < 200; n++) begin
            logic rd;
            logic [63:0] addr;
            logic [1:0] resp;
            rd = 1'($urandom);
            addr = 64'h80000000 + 64'($urandom_range(0, 15) * 8) + 64'($urandom_range(0, 7));
            resp = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            arDelay = $urandom_range(0, 3); awDelay = $urandom_range(0, 3); wDelay = $urandom_range(0, 3);
            rDelay = $urandom_range(0, 3); bDelay = $urandom_range(0, 3);
            applyStimulus(rd, addr, rnTab[$urandom_range(0, 5)], 1'($urandom), {$urandom, $urandom},
                          (rd && $urandom_range(0, 1) == 0) ? 8'h00 : maskTab[$urandom_range(0, 3)],
                          resp, lat);
        end

        repeat (5) @(negedge clk);
        checkOutput("stall_while_busy", {63'd0, stallViolation}, 64'd0);
        checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
